// File: rtl/f2s_stream_pingpong_ctrl.sv
// f2s_stream_pingpong_ctrl
// Ping-pong write scheduler for the FPGA-to-HPS stream BRAM. Incoming
// valid/ready words fill one half of the BRAM. Each completed half is flagged
// to the HPS through the stream-event PIO. The HPS drains that half and then
// returns it to this block with an ack bit.
//
// Ports
//   clk         system clock, rising edge
//   reset       synchronous, active-high
//   ctrl_in     PIO out_port: [0] enable, [1] ack half0, [2] ack half1,
//               [3] clear overflow
//   status_out  PIO in_port: [1:0] half ready, [2] overflow, [3] busy,
//               [15:4] zero, [31:16] frame count
//   src_valid   source word valid
//   src_data    source word
//   src_ready   word accepted this cycle when src_valid is also high
//   bram_we     BRAM write enable, one cycle after the accept
//   bram_addr   {half, word_ptr}
//   bram_wdata  BRAM write data
module f2s_stream_pingpong_ctrl #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       ctrl_in,
  output logic [31:0]       status_out,
  input  logic              src_valid,
  input  logic [DATA_W-1:0] src_data,
  output logic              src_ready,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_wdata
);

  localparam int unsigned PTR_W   = ADDR_W - 1;
  localparam int unsigned FRAME_W = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FILL      = 2'd1,
    WAIT_FREE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               half_q, half_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [1:0]         ready_q, ready_d;
  logic               ovf_q, ovf_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [1:0]         ack_q;
  logic               clr_q;

  logic       enable;
  logic       accept;
  logic       last_word;
  logic       clr_rise;
  logic [1:0] ack_rise;
  logic [1:0] ready_acked;
  logic       unused_ctrl;

  assign enable      = ctrl_in[0];
  assign accept      = src_valid & (state_q == FILL);
  assign last_word   = &ptr_q;
  assign ack_rise    = ctrl_in[2:1] & ~ack_q;
  assign clr_rise    = ctrl_in[3] & ~clr_q;
  assign ready_acked = ready_q & ~ack_rise;
  assign unused_ctrl = ^ctrl_in[31:4];

  // Register-only outputs, so the PIO always samples a stable word
  assign src_ready  = (state_q == FILL);
  assign status_out = {frame_q, 12'd0, (state_q != IDLE), ovf_q, ready_q};

  // Next-state, pointer, ready-flag and overflow logic
  always_comb begin
    state_d = state_q;
    half_d  = half_q;
    ptr_d   = ptr_q;
    ready_d = ready_acked;
    ovf_d   = ovf_q;
    frame_d = frame_q;

    // A stall with data pending beats a simultaneous clear request
    if (clr_rise) begin
      ovf_d = 1'b0;
    end
    if ((state_q == WAIT_FREE) && src_valid) begin
      ovf_d = 1'b1;
    end

    if (accept) begin
      if (last_word) begin
        ptr_d           = '0;
        ready_d[half_q] = 1'b1;
        half_d          = ~half_q;
        frame_d         = frame_q + FRAME_W'(1);
      end else begin
        ptr_d = ptr_q + PTR_W'(1);
      end
    end

    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = ready_q[half_q] ? WAIT_FREE : FILL;
        end
      end
      FILL: begin
        // An ack for the next half arriving with the final word avoids a stall
        if (accept && last_word) begin
          state_d = ready_acked[~half_q] ? WAIT_FREE : FILL;
        end
      end
      WAIT_FREE: begin
        // Resume once the registered flag shows the half is free
        if (!ready_q[half_q]) begin
          state_d = FILL;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Disable discards a partial half; the half is refilled from word 0
    if (!enable) begin
      state_d = IDLE;
      ptr_d   = '0;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      half_q     <= 1'b0;
      ptr_q      <= '0;
      ready_q    <= 2'b00;
      ovf_q      <= 1'b0;
      frame_q    <= '0;
      ack_q      <= 2'b00;
      clr_q      <= 1'b0;
      bram_we    <= 1'b0;
      bram_addr  <= '0;
      bram_wdata <= '0;
    end else begin
      state_q <= state_d;
      half_q  <= half_d;
      ptr_q   <= ptr_d;
      ready_q <= ready_d;
      ovf_q   <= ovf_d;
      frame_q <= frame_d;
      ack_q   <= ctrl_in[2:1];
      clr_q   <= ctrl_in[3];
      bram_we <= accept;
      if (accept) begin
        bram_addr  <= {half_q, ptr_q};
        bram_wdata <= src_data;
      end
    end
  end

endmodule

// File: tb/tb_f2s_stream_pingpong_ctrl.sv
// Bench for f2s_stream_pingpong_ctrl: directed scenarios followed by random
// traffic, with expected BRAM writes queued by a reference model and consumed
// by an independent monitor.
module tb_f2s_stream_pingpong_ctrl;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 32;
  localparam int HALF = 512;
  localparam logic [31:0] EN  = 32'h1;
  localparam logic [31:0] A0  = 32'h2;
  localparam logic [31:0] A1  = 32'h4;
  localparam logic [31:0] CLR = 32'h8;
  localparam int MI = 0;
  localparam int MF = 1;
  localparam int MW = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [31:0]       ctrl_in;
  logic [31:0]       status_out;
  logic              src_valid;
  logic [DATA_W-1:0] src_data;
  logic              src_ready;
  logic              bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_wdata;

  f2s_stream_pingpong_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .ctrl_in    (ctrl_in),
    .status_out (status_out),
    .src_valid  (src_valid),
    .src_data   (src_data),
    .src_ready  (src_ready),
    .bram_we    (bram_we),
    .bram_addr  (bram_addr),
    .bram_wdata (bram_wdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          tag;
    logic [9:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  bit   started = 0;

  // Reference model state
  int          m_mode;
  int          m_ptr;
  bit          m_half;
  bit [1:0]    m_ready;
  bit          m_ovf;
  bit [15:0]   m_frame;
  bit [1:0]    m_ack;
  bit          m_clr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] model_status();
    return {m_frame, 12'd0, (m_mode != MI), m_ovf, m_ready};
  endfunction

  // Reference model: one step per clock from the inputs seen at that edge
  bit       r_en, r_acc, r_done, r_crise, r_oh;
  bit [1:0] r_rise, r_old_ready, r_new_ready;
  int       r_old_mode;
  always @(posedge clk) begin
    if (reset === 1'b1) begin
      started = 1;
      m_mode = MI; m_ptr = 0; m_half = 0; m_ready = 2'b00; m_ovf = 0;
      m_frame = 16'd0; m_ack = 2'b00; m_clr = 0;
      exp_q.delete();
    end else if (started) begin
      r_en        = ctrl_in[0];
      r_rise      = ctrl_in[2:1] & ~m_ack;
      r_crise     = ctrl_in[3] & ~m_clr;
      r_old_mode  = m_mode;
      r_old_ready = m_ready;
      r_oh        = m_half;
      r_acc       = (m_mode == MF) && src_valid;
      r_done      = 0;
      r_new_ready = m_ready & ~r_rise;
      if (r_crise) m_ovf = 0;
      if (r_old_mode == MW && src_valid) m_ovf = 1;
      if (r_acc) begin
        exp_q.push_back('{tag: cyc, addr: 10'(int'(r_oh) * HALF + m_ptr), data: src_data});
        if (m_ptr == HALF - 1) begin
          r_done = 1;
          m_ptr = 0;
          r_new_ready[r_oh] = 1'b1;
          m_half = !r_oh;
          m_frame = m_frame + 16'd1;
        end else begin
          m_ptr++;
        end
      end
      if (!r_en) begin
        m_mode = MI;
        m_ptr = 0;
      end else if (r_old_mode == MI) begin
        m_mode = r_old_ready[r_oh] ? MW : MF;
      end else if (r_old_mode == MF && r_done) begin
        m_mode = (r_old_ready[m_half] && !r_rise[m_half]) ? MW : MF;
      end else if (r_old_mode == MW && !r_old_ready[r_oh]) begin
        m_mode = MF;
      end
      m_ready = r_new_ready;
      m_ack = ctrl_in[2:1];
      m_clr = ctrl_in[3];
    end
    cyc++;
  end

  // Monitor: status every cycle, BRAM writes against the scoreboard queue
  bit   mon_exp_we;
  exp_t mon_e;
  always @(negedge clk) begin
    if (started) begin
      chk("status_out", status_out, model_status());
      chk("src_ready", 32'(src_ready), 32'(m_mode == MF));
      mon_exp_we = (exp_q.size() > 0) && (exp_q[0].tag == cyc - 1);
      chk("bram_we", 32'(bram_we), 32'(mon_exp_we));
      if (mon_exp_we) begin
        mon_e = exp_q.pop_front();
        if (bram_we === 1'b1) begin
          chk("bram_addr", 32'(bram_addr), 32'(mon_e.addr));
          chk("bram_wdata", bram_wdata, mon_e.data);
        end
      end
    end
  end

  task automatic drive(input logic r, input logic [31:0] c, input logic v);
    @(negedge clk);
    reset     = r;
    ctrl_in   = c;
    src_valid = v;
    src_data  = $urandom;
  endtask

  logic [31:0] rc;
  logic        rr;
  initial begin
    reset = 1'b1; ctrl_in = '0; src_valid = 1'b0; src_data = '0;
    repeat (3) drive(1'b1, 32'h0, 1'b0);
    drive(1'b0, 32'h0, 1'b0);
    chk("reset_status", status_out, 32'h0);
    chk("reset_src_ready", 32'(src_ready), 32'h0);
    chk("reset_addr", 32'(bram_addr), 32'h0);
    chk("reset_wdata", bram_wdata, 32'h0);

    // First half: 512 back-to-back words
    drive(1'b0, EN, 1'b0);
    repeat (HALF) drive(1'b0, EN, 1'b1);
    drive(1'b0, EN, 1'b1);
    chk("half0_done_status", status_out, 32'h0001_0009);
    chk("half0_done_src_ready", 32'(src_ready), 32'h1);

    // Second half without ack: stall, then overflow
    repeat (HALF - 1) drive(1'b0, EN, 1'b1);
    drive(1'b0, EN, 1'b1);
    chk("both_full_status", status_out, 32'h0002_000B);
    chk("both_full_src_ready", 32'(src_ready), 32'h0);
    drive(1'b0, EN, 1'b1);
    chk("overflow_set", status_out, 32'h0002_000F);

    // Ack half0: flag clears, FILL one cycle later
    drive(1'b0, EN | A0, 1'b1);
    drive(1'b0, EN | A0, 1'b1);
    chk("ack0_status", status_out, 32'h0002_000E);
    chk("ack0_still_wait", 32'(src_ready), 32'h0);
    drive(1'b0, EN | A0, 1'b1);
    chk("ack0_resume", 32'(src_ready), 32'h1);

    // Refill half0 (ack0 held, then ack1 rises mid-fill)
    repeat (255) drive(1'b0, EN | A0, 1'b1);
    repeat (256) drive(1'b0, EN | A1, 1'b1);
    // Fill half1; last word coincides with an ack0 rise
    repeat (HALF - 1) drive(1'b0, EN, 1'b1);
    drive(1'b0, EN | A0, 1'b1);
    drive(1'b0, EN | A0, 1'b1);
    chk("ack_and_complete", status_out, 32'h0004_000E);
    chk("ack_and_complete_nostall", 32'(src_ready), 32'h1);

    // Drop enable partway through a half, then re-enable
    repeat (99) drive(1'b0, EN, 1'b1);
    drive(1'b0, 32'h0, 1'b1);
    drive(1'b0, 32'h0, 1'b0);
    chk("disable_status", status_out, 32'h0004_0006);
    chk("disable_src_ready", 32'(src_ready), 32'h0);
    drive(1'b0, EN, 1'b0);
    drive(1'b0, EN, 1'b1);
    drive(1'b0, EN, 1'b0);
    chk("reenable_status", status_out, 32'h0004_000E);

    // Overflow clear without a stall
    drive(1'b0, EN | CLR, 1'b0);
    drive(1'b0, EN, 1'b0);
    chk("ovf_cleared", status_out, 32'h0004_000A);

    // Clear request during a stall with data pending: overflow stays set
    repeat (HALF - 1) drive(1'b0, EN, 1'b1);
    drive(1'b0, EN, 1'b1);
    drive(1'b0, EN | CLR, 1'b1);
    drive(1'b0, EN, 1'b1);
    chk("ovf_set_wins", status_out, 32'h0005_000F);

    // Reset in the middle of a fill
    drive(1'b0, EN | A1, 1'b0);
    drive(1'b0, EN, 1'b0);
    repeat (5) drive(1'b0, EN, 1'b1);
    drive(1'b1, EN, 1'b1);
    drive(1'b0, 32'h0, 1'b0);
    chk("midfill_reset_status", status_out, 32'h0);
    chk("midfill_reset_we", 32'(bram_we), 32'h0);
    chk("midfill_reset_addr", 32'(bram_addr), 32'h0);

    // Random traffic against the model
    rc = EN;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(199) == 0) rc[0] = ~rc[0];
      if ($urandom_range(39) == 0)  rc[1] = ~rc[1];
      if ($urandom_range(39) == 0)  rc[2] = ~rc[2];
      if ($urandom_range(29) == 0)  rc[3] = ~rc[3];
      rr = ($urandom_range(1499) == 0);
      drive(rr, rc, ($urandom_range(9) < 8));
    end

    drive(1'b0, 32'h0, 1'b0);
    drive(1'b0, 32'h0, 1'b0);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
